// File: rtl/dff_shift_bank_if.sv
// Bus bundle for dff_shift_bank: control/data inputs driven by the master,
// stage contents and occupancy status driven by the bank (slave).
interface dff_shift_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   clr;
    logic                   en;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       sin;
    logic                   sin_vld;
    logic                   rot;
    logic [WIDTH*DEPTH-1:0] pin;
    logic [WIDTH*DEPTH-1:0] pout;
    logic [DEPTH-1:0]       vld;
    logic [WIDTH-1:0]       sout_r;
    logic [WIDTH-1:0]       sout_l;
    logic [CW-1:0]          fill_cnt;
    logic                   full;
    logic                   empty;

    modport master (
        output clr, en, mode, sin, sin_vld, rot, pin,
        input  pout, vld, sout_r, sout_l, fill_cnt, full, empty
    );

    modport slave (
        input  clr, en, mode, sin, sin_vld, rot, pin,
        output pout, vld, sout_r, sout_l, fill_cnt, full, empty
    );
endinterface

// File: rtl/dff_shift_bank.sv
// Universal shift register bank: DEPTH stages of WIDTH bits, each with a valid
// flag. Modes: hold, shift right, shift left, parallel load. Fill level, full
// and empty are registered alongside the valid flags so they never disagree.
// Optional feature macro: DFF_SHIFT_BANK_ROTATE_EN (rot turns shifts into
// rotations; when undefined rot is ignored).
module dff_shift_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dff_shift_bank_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, empty_q;

    // Data entering at each end of the bank: serial input or the wrapped stage.
    logic [WIDTH-1:0] r_in, l_in;
    logic             r_in_vld, l_in_vld;

`ifdef DFF_SHIFT_BANK_ROTATE_EN
    assign r_in     = bus.rot ? stage_q[DEPTH-1] : bus.sin;
    assign r_in_vld = bus.rot ? vld_q[DEPTH-1]   : bus.sin_vld;
    assign l_in     = bus.rot ? stage_q[0]       : bus.sin;
    assign l_in_vld = bus.rot ? vld_q[0]         : bus.sin_vld;
`else
    logic unused_rot;
    assign unused_rot = bus.rot;
    assign r_in       = bus.sin;
    assign r_in_vld   = bus.sin_vld;
    assign l_in       = bus.sin;
    assign l_in_vld   = bus.sin_vld;
`endif

    // Next stage/valid contents: clr beats enable, enable beats mode.
    // NOTE: every target gets its current value first so no path leaves it
    // unassigned, which is what keeps this combinational block latch-free.
    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
            vld_d = '0;
        end else if (bus.en) begin
            case (mode_e'(bus.mode))
                MODE_RIGHT: begin
                    stage_d[0] = r_in;
                    vld_d[0]   = r_in_vld;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                        vld_d[i]   = vld_q[i-1];
                    end
                end
                MODE_LEFT: begin
                    stage_d[DEPTH-1] = l_in;
                    vld_d[DEPTH-1]   = l_in_vld;
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        stage_d[i] = stage_q[i+1];
                        vld_d[i]   = vld_q[i+1];
                    end
                end
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) stage_d[i] = bus.pin[i*WIDTH +: WIDTH];
                    vld_d = '1;
                end
                default: ;
            endcase
        end
    end

    // Occupancy derived from the next valid vector so it lands on the same edge.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CW'(vld_d[i]);
    end

    // Stage, valid and status registers.
    // NOTE: the stage array is reset too: the bank must read as all-zero data
    // right after reset, not just as empty.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            vld_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pout
        assign bus.pout[g*WIDTH +: WIDTH] = stage_q[g];
    end

    assign bus.vld      = vld_q;
    assign bus.sout_r   = stage_q[DEPTH-1];
    assign bus.sout_l   = stage_q[0];
    assign bus.fill_cnt = cnt_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
endmodule

// File: tb/tb_dff_shift_bank.sv
// Self-checking bench for dff_shift_bank: directed scenarios plus randomized
// stimulus compared against a queue-based model of the bank.
module tb_dff_shift_bank;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    dff_shift_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dff_shift_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: index 0 is stage 0 (left end); shifting right pushes at the front.
    logic [WIDTH-1:0] m_data [$];
    logic             m_vld  [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_data.delete();
        m_vld.delete();
        repeat (DEPTH) begin
            m_data.push_back('0);
            m_vld.push_back(1'b0);
        end
    endfunction

    function automatic void model_apply();
        logic [WIDTH-1:0] d;
        logic             v;
        logic             use_rot;
        use_rot = 1'b0;
`ifdef DFF_SHIFT_BANK_ROTATE_EN
        use_rot = bus.rot;
`endif
        if (bus.clr) begin
            model_reset();
        end else if (bus.en) begin
            case (bus.mode)
                2'b01: begin
                    d = m_data.pop_back();
                    v = m_vld.pop_back();
                    m_data.push_front(use_rot ? d : bus.sin);
                    m_vld.push_front(use_rot ? v : bus.sin_vld);
                end
                2'b10: begin
                    d = m_data.pop_front();
                    v = m_vld.pop_front();
                    m_data.push_back(use_rot ? d : bus.sin);
                    m_vld.push_back(use_rot ? v : bus.sin_vld);
                end
                2'b11: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        m_data[i] = bus.pin[i*WIDTH +: WIDTH];
                        m_vld[i]  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check_all();
        logic [WIDTH*DEPTH-1:0] exp_pout;
        logic [DEPTH-1:0]       exp_vld;
        int                     fill;
        fill = 0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_pout[i*WIDTH +: WIDTH] = m_data[i];
            exp_vld[i]                 = m_vld[i];
            fill += int'(m_vld[i]);
        end
        check("pout", 64'(bus.pout), 64'(exp_pout));
        check("vld", 64'(bus.vld), 64'(exp_vld));
        check("sout_r", 64'(bus.sout_r), 64'(m_data[DEPTH-1]));
        check("sout_l", 64'(bus.sout_l), 64'(m_data[0]));
        check("fill_cnt", 64'(bus.fill_cnt), 64'(fill));
        check("full", 64'(bus.full), 64'(fill == DEPTH));
        check("empty", 64'(bus.empty), 64'(fill == 0));
    endtask

    // Apply current inputs to the model, then sample the DUT just after the edge.
    task automatic tick();
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clr     = 1'b0;
        bus.en      = 1'b0;
        bus.mode    = 2'b00;
        bus.sin     = '0;
        bus.sin_vld = 1'b0;
        bus.rot     = 1'b0;
    endtask

    task automatic do_load(input logic [WIDTH*DEPTH-1:0] data);
        idle();
        bus.en   = 1'b1;
        bus.mode = 2'b11;
        bus.pin  = data;
        tick();
        idle();
    endtask

    initial begin
        idle();
        bus.pin = '0;
        rst_n   = 1'b0;
        model_reset();
        #12;
        check_all();
        check("reset_empty", 64'(bus.empty), 64'd1);
        rst_n = 1'b1;

        // Parallel load.
        do_load(32'hDDCCBBAA);
        check("load_pout", 64'(bus.pout), 64'hDDCCBBAA);
        check("load_vld", 64'(bus.vld), 64'hF);
        check("load_full", 64'(bus.full), 64'd1);
        check("load_fill", 64'(bus.fill_cnt), 64'd4);
        check("load_sout_l", 64'(bus.sout_l), 64'hAA);
        check("load_sout_r", 64'(bus.sout_r), 64'hDD);
        check_all();

        // Asynchronous reset mid-cycle while full.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_pout", 64'(bus.pout), 64'd0);
        check("arst_vld", 64'(bus.vld), 64'd0);
        check("arst_fill", 64'(bus.fill_cnt), 64'd0);
        check("arst_empty", 64'(bus.empty), 64'd1);
        check("arst_full", 64'(bus.full), 64'd0);
        rst_n = 1'b1;

        // Serial fill by shifting right.
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            bus.en      = 1'b1;
            bus.mode    = 2'b01;
            bus.sin     = WIDTH'(8'h11 * (i + 1));
            bus.sin_vld = 1'b1;
            tick();
            check("fill_step", 64'(bus.fill_cnt), 64'(i + 1));
            check("fill_full", 64'(bus.full), 64'(i == DEPTH - 1));
        end
        check("fill_pout", 64'(bus.pout), 64'h11223344);
        check_all();

        // Left drain from a loaded bank.
        do_load(32'hDDCCBBAA);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_sout_l", 64'(bus.sout_l), 64'(8'hAA + 8'h11 * i));
            idle();
            bus.en   = 1'b1;
            bus.mode = 2'b10;
            tick();
            check("drain_fill", 64'(bus.fill_cnt), 64'(DEPTH - 1 - i));
        end
        check("drain_empty", 64'(bus.empty), 64'd1);
        check_all();

        // clr outranks a load; en=0 outranks a shift.
        do_load(32'hDDCCBBAA);
        bus.clr  = 1'b1;
        bus.en   = 1'b1;
        bus.mode = 2'b11;
        bus.pin  = 32'h12345678;
        tick();
        check("prio_clr_pout", 64'(bus.pout), 64'd0);
        check("prio_clr_empty", 64'(bus.empty), 64'd1);
        do_load(32'hDDCCBBAA);
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.mode    = 2'b01;
            bus.sin     = 8'h5A;
            bus.sin_vld = 1'b1;
            tick();
            check("prio_hold_pout", 64'(bus.pout), 64'hDDCCBBAA);
        end
        check_all();

        // Shift right with rot set.
        do_load(32'hDDCCBBAA);
        bus.en   = 1'b1;
        bus.mode = 2'b01;
        bus.rot  = 1'b1;
        tick();
`ifdef DFF_SHIFT_BANK_ROTATE_EN
        check("rot_pout", 64'(bus.pout), 64'hCCBBAADD);
        check("rot_fill", 64'(bus.fill_cnt), 64'd4);
`else
        check("rot_pout", 64'(bus.pout), 64'hCCBBAA00);
        check("rot_fill", 64'(bus.fill_cnt), 64'd3);
`endif
        check_all();

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 400; n++) begin
            bus.clr     = ($urandom_range(0, 15) == 0);
            bus.en      = ($urandom_range(0, 7) != 0);
            bus.mode    = 2'($urandom_range(0, 3));
            bus.sin     = WIDTH'($urandom);
            bus.sin_vld = 1'($urandom);
            bus.rot     = 1'($urandom);
            bus.pin     = (WIDTH*DEPTH)'($urandom);
            tick();
            check_all();
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dff_shift_bank.md
Name: dff_shift_bank

Overview:
- Parametrised bank of D-flip-flop stages forming a universal shift register.
- Each stage is WIDTH bits wide and there are DEPTH stages.
- Modes are hold, shift right, shift left and parallel load.
- Each stage carries a valid flag, and the block reports fill level, full and empty.
- Successor to the single-bit flip-flop exercises; used as a reusable delay-line / serial-parallel converter in later designs.

Parameters:
- WIDTH, 8, bits per stage (>=1)
- DEPTH, 4, number of stages (>=2)
- CW, $clog2(DEPTH+1), width of fill_cnt (derived localparam, not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear of all data and valid flags
- en  input  1  operation enable; 0 = hold regardless of mode
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- sin  input  WIDTH  serial data in
- sin_vld  input  1  valid flag accompanying sin
- rot  input  1  rotate request (used only with DFF_SHIFT_BANK_ROTATE_EN)
- pin  input  WIDTH*DEPTH  parallel load data; stage i = pin[i*WIDTH +: WIDTH]
- pout  output  WIDTH*DEPTH  current stage contents, same packing as pin
- vld  output  DEPTH  per-stage valid flags
- sout_r  output  WIDTH  stage DEPTH-1 data (right end)
- sout_l  output  WIDTH  stage 0 data (left end)
- fill_cnt  output  CW  number of set bits in vld
- full  output  1  all vld set
- empty  output  1  no vld set

Behaviour:
- Reset: rst_n low asynchronously clears all stages, vld, fill_cnt to 0; full=0, empty=1. Release is synchronous to the next clk edge.
- Priority per edge: clr > !en (hold) > mode.
- clr=1: all stages and vld become 0 on the next edge, regardless of en/mode.
- Mode 00 / en=0: no change.
- Mode 01, shift right:
  - stage[0]<=sin, vld[0]<=sin_vld
  - stage[i]<=stage[i-1], vld[i]<=vld[i-1] for i>=1
  - old stage[DEPTH-1] is discarded.
- Mode 10, shift left:
  - stage[DEPTH-1]<=sin, vld[DEPTH-1]<=sin_vld
  - stage[i]<=stage[i+1], vld[i]<=vld[i+1]
  - old stage[0] is discarded.
- Mode 11: stage[i]<=pin slice i; all vld<=1.
- Latency: every change is visible on pout/vld/sout_* one clk after the qualifying edge. No combinational path from inputs to outputs.
- fill_cnt, full, empty:
  - registered and updated on the same edge as vld, so they are always consistent with vld.
  - fill_cnt never exceeds DEPTH.
  - full and empty are never both 1.
- sout_r/sout_l are direct taps of the stage registers (no extra delay).
- Shifting with sin_vld=0 drains the bank; fill_cnt reaches 0 after DEPTH shifts from full.
- Mid-operation reset: any partial state is lost; first post-reset edge behaves as if from a cleared bank.

Optional Feature:
- Macro DFF_SHIFT_BANK_ROTATE_EN.
- Defined: when rot=1 with mode 01, stage[0]<=old stage[DEPTH-1] and its vld (sin/sin_vld ignored). With mode 10, stage[DEPTH-1]<=old stage[0] and its vld. Data and fill_cnt are preserved across rotation.
- Not defined: rot port exists but is ignored; shifts always take sin.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with bank full -> pout=0, vld=0, fill_cnt=0, empty=1 immediately (before next clk edge).
- Parallel load with pin=32'hDDCCBBAA, en=1, mode=11 -> next cycle pout=32'hDDCCBBAA, vld=4'b1111, full=1, fill_cnt=4, sout_l=8'hAA, sout_r=8'hDD.
- Serial fill: from empty, shift right 4 cycles with sin=11,22,33,44, sin_vld=1 -> pout=32'h11223344, fill_cnt steps 1,2,3,4, full asserts on 4th edge.
- Left drain: from the parallel-load state, shift left 4 cycles with sin_vld=0 -> sout_l sequence AA,BB,CC,DD on successive cycles; fill_cnt 3,2,1,0; empty=1 at end.
- Priority: from the parallel-load state, clr=1 with en=1, mode=11 -> bank cleared, not loaded. Then en=0, mode=01 for 3 cycles -> no change.
- Rotate (macro defined): from the parallel-load state, mode=01, rot=1 -> pout=32'hCCBBAADD, fill_cnt stays 4. Without macro, same stimulus with sin=8'h00, sin_vld=0 -> pout=32'hCCBBAA00, fill_cnt=3.
